// File: rtl/pico_axi_pkg.sv
// pico_axi_pkg: AXI constants and width helpers shared by the pico AXI bridge blocks.
package pico_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  function automatic int ptr_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction
endpackage

// File: rtl/pico_axi_wdata_upsizer.sv
// pico_axi_wdata_upsizer: packs narrow slave W beats into wide master W beats.
module pico_axi_wdata_upsizer
  import pico_axi_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH         = 8,
  parameter int C_AXI_SLAVE_DATA_WIDTH = 128,
  parameter int UPSIZE_RATIO           = 2
) (
  input  logic                                             aclk,
  input  logic                                             aresetn,
  input  logic [C_AXI_ID_WIDTH-1:0]                        s_axi_wid,
  input  logic [C_AXI_SLAVE_DATA_WIDTH-1:0]                s_axi_wdata,
  input  logic [C_AXI_SLAVE_DATA_WIDTH/8-1:0]              s_axi_wstrb,
  input  logic                                             s_axi_wlast,
  input  logic                                             s_axi_wvalid,
  output logic                                             s_axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]                        m_axi_wid,
  output logic [C_AXI_SLAVE_DATA_WIDTH*UPSIZE_RATIO-1:0]   m_axi_wdata,
  output logic [C_AXI_SLAVE_DATA_WIDTH*UPSIZE_RATIO/8-1:0] m_axi_wstrb,
  output logic                                             m_axi_wlast,
  output logic                                             m_axi_wvalid,
  input  logic                                             m_axi_wready
);
  localparam int SW       = C_AXI_SLAVE_DATA_WIDTH;
  localparam int SW_BYTES = SW / 8;
  localparam int MW       = SW * UPSIZE_RATIO;
  localparam int MW_BYTES = MW / 8;
  localparam int PTR_W    = ptr_w(UPSIZE_RATIO);
  generate
    if (UPSIZE_RATIO > 1) begin : g_pack
      logic [PTR_W-1:0]    ptr;
      logic [MW-1:0]       acc_data, mrg_data;
      logic [MW_BYTES-1:0] acc_strb, mrg_strb;
      logic                out_valid, s_acc, done;
      // Lanes at and above ptr are always zero in the accumulator, so OR-merge is placement.
      always_comb begin
        s_acc    = s_axi_wvalid & s_axi_wready;
        done     = s_acc & (s_axi_wlast | (ptr == PTR_W'(UPSIZE_RATIO - 1)));
        mrg_data = acc_data | (MW'(s_axi_wdata) << (SW * ptr));
        mrg_strb = acc_strb | (MW_BYTES'(s_axi_wstrb) << (SW_BYTES * ptr));
      end
      assign s_axi_wready = ~out_valid | m_axi_wready;
      assign m_axi_wvalid = out_valid;
      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          ptr         <= '0;
          acc_data    <= '0;
          acc_strb    <= '0;
          out_valid   <= 1'b0;
          m_axi_wid   <= '0;
          m_axi_wdata <= '0;
          m_axi_wstrb <= '0;
          m_axi_wlast <= 1'b0;
        end else begin
          if (s_acc) begin
            ptr      <= done ? '0 : ptr + PTR_W'(1);
            acc_data <= done ? '0 : mrg_data;
            acc_strb <= done ? '0 : mrg_strb;
          end
          if (done) begin
            m_axi_wid   <= s_axi_wid;
            m_axi_wdata <= mrg_data;
            m_axi_wstrb <= mrg_strb;
            m_axi_wlast <= s_axi_wlast;
          end
          out_valid <= done | (out_valid & ~m_axi_wready);
        end
      end
    end else begin : g_wire
      assign m_axi_wid    = s_axi_wid;
      assign m_axi_wdata  = s_axi_wdata;
      assign m_axi_wstrb  = s_axi_wstrb;
      assign m_axi_wlast  = s_axi_wlast;
      assign m_axi_wvalid = s_axi_wvalid;
      assign s_axi_wready = m_axi_wready;
    end
  endgenerate
endmodule
